fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one sync_fifo write port between NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_LEN beats, drives the FIFO write port, and back-pressures on fifo_full. It sits directly in front of the FIFO's wr_en/wr_data/full pins.

---
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers, in bursts of up to BURST_LEN beats.
// Latency: one arbitration cycle in IDLE, then one beat per cycle straight through to fifo_wr_en/fifo_wr_data.
// Backpressure: fifo_full drops req_ready and fifo_wr_en and stalls the burst in place; the grant is never dropped on full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id,
    output logic [15:0]                   beats_total
);

    // Beat counter must hold 0..BURST_LEN-1; keep at least one bit for BURST_LEN=1.
    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [BCW-1:0]  beat_cnt;

    logic            pick_vld;
    logic [IDW-1:0]  pick_id;
    logic            sel_valid;
    logic            last_beat;

    // Index base+offs wrapped into 0..NUM_REQ-1; offs never exceeds NUM_REQ-1
    // and base is always a legal index, so one subtraction is enough.
    function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    // Walk offsets downward so the smallest offset wins last.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rot_idx(rr_ptr, k)]) begin
                pick_vld = 1'b1;
                pick_id  = rot_idx(rr_ptr, k);
            end
        end
    end

    // Datapath toward the FIFO: only the granted lane is ever ready, and only while the FIFO has room.
    always_comb begin
        sel_valid    = req_valid[grant_id];
        fifo_wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        fifo_wr_en   = grant_valid & sel_valid & ~fifo_full;
        last_beat    = (beat_cnt == LAST_BEAT);
        req_ready    = '0;
        if (grant_valid && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Grant FSM with registered grant outputs and the running beat total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            beats_total <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Pointer moves only at grant time, which is what bounds each requester to one grant per round.
                    if (pick_vld) begin
                        state       <= BURST;
                        grant_valid <= 1'b1;
                        grant_id    <= pick_id;
                        rr_ptr      <= rot_idx(pick_id, 1);
                        beat_cnt    <= '0;
                    end
                end
                BURST: begin
                    if (fifo_wr_en) begin
                        beats_total <= beats_total + 16'd1;
                        if (last_beat) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end else if (!sel_valid) begin
                        // Granted producer went quiet: hand the port back early.
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end
                    // Otherwise the FIFO is full with data pending: hold everything.
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: main instance (BURST_LEN=4) checked against a write scoreboard,
// plus BURST_LEN=1 and BURST_LEN=256 instances for single-beat alternation and beats_total wrap.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] beats_total;

    logic [3:0]  b1_valid;
    logic [31:0] b1_data;
    logic [3:0]  b1_ready;
    logic        b1_wr_en;
    logic [7:0]  b1_wr_data;
    logic        b1_gv;
    logic [1:0]  b1_gid;
    logic [15:0] b1_total;

    logic [3:0]  big_valid;
    logic [31:0] big_data;
    logic [3:0]  big_ready;
    logic        big_wr_en;
    logic [7:0]  big_wr_data;
    logic        big_gv;
    logic [1:0]  big_gid;
    logic [15:0] big_total;

    logic        zero_full;

    int          vectors;
    int          miscompares;
    logic [9:0]  sb_q[$];

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant_valid(grant_valid), .grant_id(grant_id),
        .beats_total(beats_total)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .req_valid(b1_valid), .req_data(b1_data),
        .req_ready(b1_ready), .fifo_full(zero_full), .fifo_wr_en(b1_wr_en),
        .fifo_wr_data(b1_wr_data), .grant_valid(b1_gv), .grant_id(b1_gid),
        .beats_total(b1_total)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(256)) u_big (
        .clk(clk), .rst_n(rst_n), .req_valid(big_valid), .req_data(big_data),
        .req_ready(big_ready), .fifo_full(zero_full), .fifo_wr_en(big_wr_en),
        .fifo_wr_data(big_wr_data), .grant_valid(big_gv), .grant_id(big_gid),
        .beats_total(big_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, queue the expected write, check outputs just after.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic full,
                        input logic exp_wr, input logic exp_gv, input logic [1:0] exp_gid,
                        input string tag);
        logic [3:0] exp_rdy;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        fifo_full = full;
        if (exp_wr) sb_q.push_back({exp_gid, d[exp_gid*8 +: 8]});
        #1;
        exp_rdy = (exp_gv && !full) ? (4'b0001 << exp_gid) : 4'b0000;
        chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(exp_wr));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(exp_gv));
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        if (exp_gv) chk({tag, ".grant_id"}, 32'(grant_id), 32'(exp_gid));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, ".grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'd0);
        chk({tag, ".beats_total"}, 32'(beats_total), 32'd0);
    endtask

    // Pulse reset for one cycle with inputs left as they are, check the cleared outputs at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks(tag);
        @(negedge clk);
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        rst_n     = 1'b1;
    endtask

    function automatic logic [31:0] mk(input int b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(8'h80 + 16*i + b);
        return r;
    endfunction

    // Write monitor for the main instance: every FIFO write must match the head of the scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (fifo_wr_en === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL sb.unexpected: observed write %0h id %0d expected no write", fifo_wr_data, grant_id);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb.data", 32'(fifo_wr_data), 32'(e[7:0]));
                    chk("sb.id", 32'(grant_id), 32'(e[9:8]));
                end
            end
            if (fifo_full === 1'b1) chk("no_overflow", 32'(fifo_wr_en), 32'd0);
        end
    end

    initial begin
        int  nwr;
        bit  seen_max;
        bit  done;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        fifo_full   = 1'b0;
        b1_valid    = '0;
        b1_data     = '0;
        big_valid   = '0;
        big_data    = '0;
        zero_full   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 2, three beats, then valid drops.
        step(4'b0100, 32'h00A0_0000, 1'b0, 1'b0, 1'b0, 2'd0, "t1.arb");
        step(4'b0100, 32'h00A0_0000, 1'b0, 1'b1, 1'b1, 2'd2, "t1.b0");
        step(4'b0100, 32'h00A1_0000, 1'b0, 1'b1, 1'b1, 2'd2, "t1.b1");
        step(4'b0100, 32'h00A2_0000, 1'b0, 1'b1, 1'b1, 2'd2, "t1.b2");
        step(4'b0000, 32'h0,         1'b0, 1'b0, 1'b1, 2'd2, "t1.rel");
        step(4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, "t1.idle");
        chk("t1.beats_total", 32'(beats_total), 32'd3);

        // All four requesting from a fresh pointer: 0,1,2,3 with four beats each, then 0 again.
        do_reset("t2.reset");
        for (int g = 0; g < 4; g++) begin
            step(4'hF, mk(0), 1'b0, 1'b0, 1'b0, 2'd0, "t2.idle");
            for (int b = 0; b < 4; b++) step(4'hF, mk(b), 1'b0, 1'b1, 1'b1, 2'(g), "t2.beat");
        end
        step(4'hF, mk(0), 1'b0, 1'b0, 1'b0, 2'd0, "t2.idle4");
        chk("t2.beats_total", 32'(beats_total), 32'd16);
        step(4'hF, mk(5), 1'b0, 1'b1, 1'b1, 2'd0, "t2.wrap_grant");
        step(4'h0, mk(0), 1'b0, 1'b0, 1'b1, 2'd0, "t2.rel");
        step(4'h0, mk(0), 1'b0, 1'b0, 1'b0, 2'd0, "t2.idle5");

        // Requester 1: one beat, three full cycles of stall, then the other three beats.
        step(4'b0010, 32'h0000_C000, 1'b0, 1'b0, 1'b0, 2'd0, "t3.arb");
        step(4'b0010, 32'h0000_C000, 1'b0, 1'b1, 1'b1, 2'd1, "t3.b0");
        for (int s = 0; s < 3; s++) step(4'b0010, 32'h0000_C100, 1'b1, 1'b0, 1'b1, 2'd1, "t3.stall");
        step(4'b0010, 32'h0000_C100, 1'b0, 1'b1, 1'b1, 2'd1, "t3.b1");
        step(4'b0010, 32'h0000_C200, 1'b0, 1'b1, 1'b1, 2'd1, "t3.b2");
        step(4'b0010, 32'h0000_C300, 1'b0, 1'b1, 1'b1, 2'd1, "t3.b3");
        step(4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, "t3.idle");
        chk("t3.beats_total", 32'(beats_total), 32'd21);

        // Requester 1 quits after two beats while 3 waits; 3 is granted next.
        step(4'b0010, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'd0, "t4.arb");
        step(4'b1010, 32'hE000_D000, 1'b0, 1'b1, 1'b1, 2'd1, "t4.b0");
        step(4'b1010, 32'hE000_D100, 1'b0, 1'b1, 1'b1, 2'd1, "t4.b1");
        step(4'b1000, 32'hE000_0000, 1'b0, 1'b0, 1'b1, 2'd1, "t4.rel");
        step(4'b1000, 32'hE000_0000, 1'b0, 1'b0, 1'b0, 2'd0, "t4.arb3");
        step(4'b1000, 32'hE000_0000, 1'b0, 1'b1, 1'b1, 2'd3, "t4.g3");
        step(4'b0000, 32'h0,         1'b0, 1'b0, 1'b1, 2'd3, "t4.rel3");
        step(4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, "t4.idle");
        chk("t4.beats_total", 32'(beats_total), 32'd24);

        // Reset in the middle of a requester-1 burst; the search must restart at 0, so 1 wins over 3.
        step(4'b0010, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 2'd0, "t5.arb");
        step(4'b0010, 32'h0000_F000, 1'b0, 1'b1, 1'b1, 2'd1, "t5.b0");
        step(4'b0010, 32'h0000_F100, 1'b0, 1'b1, 1'b1, 2'd1, "t5.b1");
        do_reset("t5.reset");
        step(4'b1010, 32'h3300_7700, 1'b0, 1'b0, 1'b0, 2'd0, "t5.arb");
        step(4'b1010, 32'h3300_7700, 1'b0, 1'b1, 1'b1, 2'd1, "t5.regrant");
        step(4'b0000, 32'h0,         1'b0, 1'b0, 1'b1, 2'd1, "t5.rel");
        step(4'b0000, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, "t5.idle");

        // BURST_LEN=1: requesters 0 and 1 alternate one beat per grant with an idle cycle between.
        @(negedge clk);
        b1_valid = 4'b0011;
        b1_data  = 32'h0000_5150;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("t6.b1.idle_gv", 32'(b1_gv), 32'd0);
                chk("t6.b1.idle_wr", 32'(b1_wr_en), 32'd0);
            end else begin
                chk("t6.b1.gv", 32'(b1_gv), 32'd1);
                chk("t6.b1.gid", 32'(b1_gid), 32'((k / 2) % 2));
                chk("t6.b1.wr", 32'(b1_wr_en), 32'd1);
                chk("t6.b1.data", 32'(b1_wr_data), 32'(8'h50 + (k / 2) % 2));
            end
            @(negedge clk);
        end
        b1_valid = 4'b0000;
        #1;
        chk("t6.b1.beats_total", 32'(b1_total), 32'd4);

        // beats_total wrap: 65536 writes through the long-burst instance must land back on 0.
        big_data  = 32'h0000_005A;
        big_valid = 4'b0001;
        nwr      = 0;
        seen_max = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 70000 && !done; c++) begin
            @(negedge clk);
            #1;
            if (nwr == 65535 && !seen_max) begin
                chk("t6.total_max", 32'(big_total), 32'h0000_FFFF);
                seen_max = 1'b1;
            end
            if (nwr == 65536) begin
                chk("t6.total_wrap", 32'(big_total), 32'd0);
                done = 1'b1;
            end else if (big_wr_en === 1'b1) begin
                nwr++;
            end
        end
        big_valid = 4'b0000;
        if (!done) begin
            vectors++;
            miscompares++;
            $error("FAIL t6.wrap_timeout: observed %0d writes expected 65536 within cycle budget", nwr);
        end

        chk("sb.drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
